// File: rtl/spi_master_if.sv
// Bus between spi_master and its user/slave: parallel start/busy/done handshake plus the SPI pins.
// The master modport is the spi_master's view; slave is the view of everything around it.
interface spi_master_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  ss;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, mosi, ss
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, mosi, ss
    );
endinterface

// File: rtl/spi_master.sv
// CPOL=0 SPI master: mosi changes on falling sclk, miso sampled on rising sclk, sclk = clk/(2*CLK_DIV).
// Optional macro SPI_MASTER_LSB_FIRST_EN switches both directions to LSB-first; timing is unchanged.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic          clk,
    input  logic          rst,
    spi_master_if.master  bus,
    output logic [1:0]    dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  ss_q, ss_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  tx_first;
    logic                  tx_next;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic [DATA_WIDTH-1:0] rx_shifted;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_first   = bus.tx_data[0];
    assign tx_next    = tx_q[1];
    assign tx_shifted = tx_q >> 1;
    assign rx_shifted = {bus.miso, rx_q[DATA_WIDTH-1:1]};
`else
    assign tx_first   = bus.tx_data[DATA_WIDTH-1];
    assign tx_next    = tx_q[DATA_WIDTH-2];
    assign tx_shifted = tx_q << 1;
    assign rx_shifted = {rx_q[DATA_WIDTH-2:0], bus.miso};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_q      <= ss_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Handshake: start is taken only in IDLE outside the done cycle; busy covers the
    // transfer up to the cycle before the single-cycle done pulse; nothing is queued.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_d      = ss_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                ss_d   = 1'b1;
                sclk_d = 1'b0;
                if (bus.start && !done_q) begin
                    tx_d      = bus.tx_data;
                    mosi_d    = tx_first;
                    div_d     = DIV_RELOAD;
                    bit_cnt_d = '0;
                    ss_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = LEAD;
                end
            end
            LEAD: begin
                if (div_q == '0) begin
                    div_d   = DIV_RELOAD;
                    sclk_d  = 1'b1;
                    rx_d    = rx_shifted;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_q == '0) begin
                    div_d = DIV_RELOAD;
                    if (sclk_q) begin
                        sclk_d    = 1'b0;
                        tx_d      = tx_shifted;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        // Last falling edge: line parks at 0 for the trailing gap.
                        if (bit_cnt_q == LAST_IDX) begin
                            mosi_d  = 1'b0;
                            state_d = TRAIL;
                        end else begin
                            mosi_d = tx_next;
                        end
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = rx_shifted;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            TRAIL: begin
                if (div_q == '0) begin
                    div_d     = '0;
                    bit_cnt_d = '0;
                    ss_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                    state_d   = IDLE;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.ss      = ss_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: table of directed transfers, randomized transfers,
// and hand-written reset / back-to-back / start-collision sequences.
module tb_spi_master;
    localparam int W = 8;
    localparam int H = 4;
    localparam int DONE_CYC = 1 + (2 * W + 1) * H;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    spi_master_if #(.DATA_WIDTH(W)) bus ();

    spi_master #(.DATA_WIDTH(W), .CLK_DIV(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] sw;
        logic [W-1:0] exp_rx;
        int           poke;
        logic [W-1:0] pdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Position in the word of the k-th bit on the wire.
    function automatic int bidx(input int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return k;
`else
        return W - 1 - k;
`endif
    endfunction

    function automatic logic sbit(input logic [W-1:0] w, input int k);
        return w[bidx(k)];
    endfunction

    // Runs one transfer from the negedge before cycle 0; returns at the negedge of cycle DONE_CYC+tail.
    task automatic do_transfer(input logic [W-1:0] tx, input logic [W-1:0] sw,
                               input logic [W-1:0] exp_rx, input int poke,
                               input logic [W-1:0] pdata, input int tail, input string tag);
        int c, rises, falls, dones, done_c, viol;
        logic prev_sclk;
        logic [W-1:0] got_mosi;
        logic [W-1:0] want;
        exp_q.push_back(exp_rx);
        bus.start   = 1'b1;
        bus.tx_data = tx;
        bus.miso    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.miso  = sbit(sw, 0);
        c = 1; rises = 0; falls = 0; dones = 0; done_c = -1; viol = 0;
        prev_sclk = 1'b0; got_mosi = '0;
        while (1) begin
            if (c == 1) begin
                check({tag, " c1_ss"}, bus.ss, 0);
                check({tag, " c1_busy"}, bus.busy, 1);
                check({tag, " c1_mosi"}, bus.mosi, tx[bidx(0)]);
            end
            if (bus.busy !== (c < DONE_CYC)) viol++;
            if (bus.ss !== (c >= DONE_CYC)) viol++;
            if (c >= 1 + 2 * W * H && bus.sclk !== 1'b0) viol++;
            if (bus.sclk && !prev_sclk) begin
                rises++;
                if (c != 1 + (2 * rises - 1) * H) viol++;
                if (rises <= W) got_mosi[bidx(rises - 1)] = bus.mosi;
            end
            if (!bus.sclk && prev_sclk) begin
                falls++;
                if (c != 1 + 2 * falls * H) viol++;
                if (falls < W) bus.miso = sbit(sw, falls);
            end
            prev_sclk = bus.sclk;
            if (bus.done) begin
                dones++;
                done_c = c;
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    check({tag, " rx_at_done"}, bus.rx_data, want);
                end else begin
                    check({tag, " unexpected_done"}, 1, 0);
                end
            end
            bus.tx_data = W'($urandom);
            bus.start   = (c == poke);
            if (c == poke) bus.tx_data = pdata;
            if (c >= DONE_CYC + tail) break;
            @(negedge clk);
            c++;
        end
        bus.start = 1'b0;
        check({tag, " sclk_rises"}, rises, W);
        check({tag, " sclk_falls"}, falls, W);
        check({tag, " done_count"}, dones, 1);
        check({tag, " done_cycle"}, done_c, DONE_CYC);
        check({tag, " mosi_word"}, got_mosi, tx);
        check({tag, " timing_window"}, viol, 0);
        check({tag, " rx_hold"}, bus.rx_data, exp_rx);
    endtask

    initial begin
        vec_t vecs[6];
        int   c, dones, viol;
        vecs[0] = '{tx: 8'hA5, sw: 8'h3C, exp_rx: 8'h3C, poke: -1,       pdata: 8'h00};
        vecs[1] = '{tx: 8'hC3, sw: 8'h96, exp_rx: 8'h96, poke: 20,       pdata: 8'h11};
        vecs[2] = '{tx: 8'h00, sw: 8'hFF, exp_rx: 8'hFF, poke: 2,        pdata: 8'hFF};
        vecs[3] = '{tx: 8'h81, sw: 8'h7E, exp_rx: 8'h7E, poke: DONE_CYC, pdata: 8'hAA};
        vecs[4] = '{tx: 8'h01, sw: 8'h80, exp_rx: 8'h80, poke: DONE_CYC - 1, pdata: 8'h55};
        vecs[5] = '{tx: 8'h6E, sw: 8'h01, exp_rx: 8'h01, poke: 1,        pdata: 8'h99};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.tx_data = '0;
        bus.miso = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ss", bus.ss, 1);
        check("reset_sclk", bus.sclk, 0);
        check("reset_mosi", bus.mosi, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_rx", bus.rx_data, 0);

        for (int i = 0; i < 6; i++) begin
            do_transfer(vecs[i].tx, vecs[i].sw, vecs[i].exp_rx, vecs[i].poke,
                        vecs[i].pdata, 4, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] tx, sw;
            int poke;
            tx = W'($urandom);
            sw = W'($urandom);
            poke = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(2, DONE_CYC));
            do_transfer(tx, sw, sw, poke, W'($urandom), 2, $sformatf("rnd%0d", i));
        end

        // Back-to-back: second start lands in the cycle right after done.
        do_transfer(8'hFF, 8'h5A, 8'h5A, -1, 8'h00, 1, "b2b_first");
        do_transfer(8'h00, 8'hA5, 8'hA5, -1, 8'h00, 2, "b2b_second");

        // Mid-transfer reset at cycle 30.
        bus.start = 1'b1;
        bus.tx_data = 8'h33;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        c = 1;
        while (c < 30) begin
            @(negedge clk);
            c++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_ss", bus.ss, 1);
        check("abort_sclk", bus.sclk, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_mosi", bus.mosi, 0);
        check("abort_done", bus.done, 0);
        check("abort_rx", bus.rx_data, 0);
        rst = 1'b0;
        dones = 0;
        viol = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.ss !== 1'b1 || bus.sclk !== 1'b0) viol++;
        end
        check("abort_no_done", dones, 0);
        check("abort_quiet", viol, 0);
        do_transfer(8'h5A, 8'hC6, 8'hC6, -1, 8'h00, 2, "after_abort");

        // rst and start in the same cycle: reset wins.
        rst = 1'b1;
        bus.start = 1'b1;
        bus.tx_data = 8'h77;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_start_ss", bus.ss, 1);
        check("rst_start_busy", bus.busy, 0);
        viol = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ss !== 1'b1 || bus.busy !== 1'b0 || bus.sclk !== 1'b0) viol++;
        end
        check("rst_start_idle", viol, 0);
        check("rst_start_rx", bus.rx_data, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
